// File: rtl/calc1_port_responder.sv
// rtl/calc1_port_responder.sv - calc1 port responder: two-cycle request, fixed-latency registered response

module calc1_port_responder #(
    parameter int unsigned LATENCY = 3
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic [3:0]  req_cmd_in,
    input  logic [31:0] req_data_in,
    output logic [1:0]  out_resp,
    output logic [31:0] out_data,
    output logic        out_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP2  = 2'd1,
        EXEC = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
    localparam logic [1:0] RESP_ERR  = 2'd2;

    state_t      state_q, state_d;
    logic [3:0]  cmd_q, cmd_d;
    logic [31:0] op1_q, op1_d;
    logic [31:0] op2_q, op2_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  resp_d;
    logic [31:0] data_d;
    logic        busy_d;

    logic [32:0] sum;
    logic [1:0]  alu_resp;
    logic [31:0] alu_data;

    // Result is formed from the latched operands; it is only sampled into the
    // outputs while in RESP, so the operands are stable by then for any latency.
    always_comb begin
        sum      = {1'b0, op1_q} + {1'b0, op2_q};
        alu_resp = RESP_ERR;
        alu_data = '0;
        case (cmd_q)
            CMD_ADD: begin
                if (!sum[32]) begin
                    alu_resp = RESP_OK;
                    alu_data = sum[31:0];
                end
            end
            CMD_SUB: begin
                if (op2_q <= op1_q) begin
                    alu_resp = RESP_OK;
                    alu_data = op1_q - op2_q;
                end
            end
            CMD_SHL: begin
                alu_resp = RESP_OK;
                alu_data = op1_q << op2_q[4:0];
            end
            CMD_SHR: begin
                alu_resp = RESP_OK;
                alu_data = op1_q >> op2_q[4:0];
            end
            default: begin
                alu_resp = RESP_ERR;
                alu_data = '0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        cnt_d   = cnt_q;
        resp_d  = RESP_NONE;
        data_d  = '0;
        case (state_q)
            IDLE: begin
                if (req_cmd_in != 4'd0) begin
                    cmd_d   = req_cmd_in;
                    op1_d   = req_data_in;
                    state_d = OP2;
                end
            end
            OP2: begin
                op2_d   = req_data_in;
                cnt_d   = CNT_LOAD;
                state_d = (LATENCY <= 1) ? RESP : EXEC;
            end
            EXEC: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_d  = alu_resp;
                data_d  = alu_data;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Busy also covers the cycle the registered response is on the outputs.
        busy_d = (state_d != IDLE) || (state_q == RESP);
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cmd_q    <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            cnt_q    <= '0;
            out_resp <= RESP_NONE;
            out_data <= '0;
            out_busy <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            cnt_q    <= cnt_d;
            out_resp <= resp_d;
            out_data <= data_d;
            out_busy <= busy_d;
        end
    end

endmodule

// File: tb/tb_calc1_port_responder.sv
// tb/tb_calc1_port_responder.sv - table-driven and randomized bench for calc1_port_responder

module tb_calc1_port_responder;

    localparam int L = 3;

    logic        c_clk;
    logic        reset;
    logic [3:0]  req_cmd_in;
    logic [31:0] req_data_in;
    logic [1:0]  out_resp;
    logic [31:0] out_data;
    logic        out_busy;

    int checks = 0;
    int errors = 0;

    calc1_port_responder #(.LATENCY(L)) dut (
        .c_clk       (c_clk),
        .reset       (reset),
        .req_cmd_in  (req_cmd_in),
        .req_data_in (req_data_in),
        .out_resp    (out_resp),
        .out_data    (out_data),
        .out_busy    (out_busy)
    );

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] data;
    } res_t;

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  resp;
        logic [31:0] data;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: unsigned arithmetic on wide integers, shift by amount mod 32.
    function automatic res_t model(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
        res_t r;
        longint unsigned s;
        int unsigned sh;
        r.resp = 2'd2;
        r.data = 32'd0;
        sh = b % 32;
        case (cmd)
            4'd1: begin
                s = longint'(a) + longint'(b);
                if (s <= 64'hFFFF_FFFF) begin
                    r.resp = 2'd1;
                    r.data = s[31:0];
                end
            end
            4'd2: if (a >= b) begin r.resp = 2'd1; r.data = a - b; end
            4'd5: begin r.resp = 2'd1; r.data = a << sh; end
            4'd6: begin r.resp = 2'd1; r.data = a >> sh; end
            default: ;
        endcase
        return r;
    endfunction

    // Called right after a falling edge; leaves the bench right after a falling edge.
    task automatic run_op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] er, input logic [31:0] ed,
                          input bit noise, input bit b2b, input string tag);
        req_cmd_in  = cmd;
        req_data_in = a;
        @(negedge c_clk);
        chk({tag, " busy_cmd"}, {31'd0, out_busy}, 32'd1);
        chk({tag, " resp_cmd"}, {30'd0, out_resp}, 32'd0);
        req_cmd_in  = noise ? 4'($urandom_range(15, 1)) : 4'd0;
        req_data_in = b;
        for (int k = 1; k <= L + 1; k++) begin
            @(negedge c_clk);
            if (k <= L) begin
                chk({tag, " resp_wait"}, {30'd0, out_resp}, 32'd0);
                chk({tag, " data_wait"}, out_data, 32'd0);
            end else begin
                chk({tag, " resp"}, {30'd0, out_resp}, {30'd0, er});
                chk({tag, " data"}, out_data, ed);
            end
            chk({tag, " busy"}, {31'd0, out_busy}, 32'd1);
            req_cmd_in  = (noise && k < L) ? 4'($urandom_range(15, 1)) : 4'd0;
            req_data_in = $urandom;
        end
        if (!b2b) begin
            @(negedge c_clk);
            chk({tag, " resp_after"}, {30'd0, out_resp}, 32'd0);
            chk({tag, " busy_after"}, {31'd0, out_busy}, 32'd0);
        end
    endtask

    vec_t vecs[$];

    initial begin
        res_t r;
        logic [3:0] cmd;
        logic [31:0] a, b;
        logic [3:0] pick[5];

        vecs.push_back('{4'd1, 32'h0000_0001, 32'h01FF_FFFF, 2'd1, 32'h0200_0000});
        vecs.push_back('{4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0000_0000});
        vecs.push_back('{4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF, 2'd1, 32'h3FFF_FFFE});
        vecs.push_back('{4'd1, 32'hFFFF_FFFE, 32'h0000_0001, 2'd1, 32'hFFFF_FFFF});
        vecs.push_back('{4'd2, 32'h0000_0001, 32'h0000_000F, 2'd2, 32'h0000_0000});
        vecs.push_back('{4'd2, 32'h0000_000F, 32'h0000_0001, 2'd1, 32'h0000_000E});
        vecs.push_back('{4'd2, 32'h0000_1234, 32'h0000_1234, 2'd1, 32'h0000_0000});
        vecs.push_back('{4'd5, 32'h8000_0001, 32'h0000_0021, 2'd1, 32'h0000_0002});
        vecs.push_back('{4'd6, 32'h8000_0000, 32'h0000_001F, 2'd1, 32'h0000_0001});
        vecs.push_back('{4'd5, 32'h1234_5678, 32'h0000_0000, 2'd1, 32'h1234_5678});
        vecs.push_back('{4'd6, 32'hDEAD_BEEF, 32'h0000_0020, 2'd1, 32'hDEAD_BEEF});
        vecs.push_back('{4'd3, 32'h0000_0005, 32'h0000_0006, 2'd2, 32'h0000_0000});
        vecs.push_back('{4'd4, 32'h0000_0005, 32'h0000_0006, 2'd2, 32'h0000_0000});
        vecs.push_back('{4'd15, 32'h0000_0001, 32'h0000_0001, 2'd2, 32'h0000_0000});

        reset       = 1'b1;
        req_cmd_in  = 4'd0;
        req_data_in = 32'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge c_clk);
            chk("reset_resp", {30'd0, out_resp}, 32'd0);
            chk("reset_data", out_data, 32'd0);
            chk("reset_busy", {31'd0, out_busy}, 32'd0);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge c_clk);
            chk("idle_resp", {30'd0, out_resp}, 32'd0);
            chk("idle_data", out_data, 32'd0);
            chk("idle_busy", {31'd0, out_busy}, 32'd0);
        end

        foreach (vecs[i])
            run_op(vecs[i].cmd, vecs[i].a, vecs[i].b, vecs[i].resp, vecs[i].data, 1'b0, 1'b0,
                   $sformatf("vec%0d", i));

        // Commands arriving in OP2/EXEC must be ignored.
        run_op(4'd1, 32'd10, 32'd20, 2'd1, 32'd30, 1'b1, 1'b0, "noise_add");

        // Back-to-back: next command issued during the response cycle.
        run_op(4'd2, 32'd100, 32'd1, 2'd1, 32'd99, 1'b0, 1'b1, "b2b_first");
        run_op(4'd1, 32'd7, 32'd8, 2'd1, 32'd15, 1'b0, 1'b0, "b2b_second");

        // Reset during EXEC aborts the operation silently.
        req_cmd_in  = 4'd1;
        req_data_in = 32'd4;
        @(negedge c_clk);
        req_cmd_in  = 4'd0;
        req_data_in = 32'd5;
        @(negedge c_clk);
        reset = 1'b1;
        @(negedge c_clk);
        reset = 1'b0;
        for (int i = 0; i < L + 3; i++) begin
            @(negedge c_clk);
            chk("abort_resp", {30'd0, out_resp}, 32'd0);
            chk("abort_busy", {31'd0, out_busy}, 32'd0);
        end
        run_op(4'd1, 32'd2, 32'd3, 2'd1, 32'd5, 1'b0, 1'b0, "post_abort_add");

        pick = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd0};
        for (int i = 0; i < 40; i++) begin
            cmd = pick[$urandom_range(4, 0)];
            if (cmd == 4'd0) cmd = 4'($urandom_range(15, 1));
            a = $urandom;
            b = ($urandom_range(1, 0) == 1) ? ($urandom & 32'h0000_FFFF) : $urandom;
            r = model(cmd, a, b);
            run_op(cmd, a, b, r.resp, r.data, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                   $sformatf("rnd%0d_cmd%0d", i, cmd));
        end
        @(negedge c_clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
